muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the ALU in the execute stage of the 5-stage pipelined core. It accepts one M-extension operation at a time and iterates UNROLL result bits per cycle. While it iterates it holds the pipeline through busy_o. Flush support lets a taken branch resolved in memory-access squash an in-flight operation. The result and destination register are presented for one cycle on done_o, to be muxed into the EX/MEM ALUResult path.

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative M-extension unit.
// Port directions are seen from the unit (slave); the pipeline side uses the master modport.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  // start_i is a request that is taken only when state_o is IDLE or DONE and flush_i is low;
  // there is no ready signal, because busy_o (state CALC) tells the issuer a request is ignored.
  // done_o is a single-cycle valid for result_o/rd_o, and both hold until the next completion.
  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;
  logic [1:0]      state_o;

  modport master (
    output start_i, flush_i, funct3_i, rs1_i, rs2_i, rd_i,
    input  busy_o, done_o, result_o, rd_o, state_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, rs1_i, rs2_i, rd_i,
    output busy_o, done_o, result_o, rd_o, state_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// UNROLL result bits per cycle, sign fix-up folded into the last iteration.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic          clk_i,
  input logic          reset_i,
  muldiv_unit_if.slave bus
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic              w_accept;
  logic              w_finish;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [2*XLEN-1:0] w_acc_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN:0]     w_sum;
  logic              w_qbit;
  logic [XLEN-1:0]   w_fix_res;

  assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.start_i && !bus.flush_i;
  assign w_finish = (r_state == CALC) && (r_cnt == CW'(1)) && !bus.flush_i;

  // Operand signedness per funct3; MUL low bits do not depend on sign, so it runs unsigned.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (bus.funct3_i)
      3'b001:         begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      3'b010:         begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
      3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      default:        begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
    endcase
  end

  assign w_sign_a = w_a_signed & bus.rs1_i[XLEN-1];
  assign w_sign_b = w_b_signed & bus.rs2_i[XLEN-1];
  assign w_mag_a  = w_sign_a ? (~bus.rs1_i + 1'b1) : bus.rs1_i;
  assign w_mag_b  = w_sign_b ? (~bus.rs2_i + 1'b1) : bus.rs2_i;

  assign w_div_zero = bus.funct3_i[2] && (bus.rs2_i == '0);
  assign w_div_ovf  = bus.funct3_i[2] && !bus.funct3_i[0] &&
                      (bus.rs1_i == INT_MIN) && (bus.rs2_i == '1);
  assign w_special  = w_div_zero || w_div_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = bus.funct3_i[1] ? bus.rs1_i : '1;
    end else begin
      w_special_res = bus.funct3_i[1] ? '0 : bus.rs1_i;
    end
  end

  // r_acc is {hi, lo}: multiply keeps {partial sum, multiplier}, divide keeps {remainder, quotient}.
  always_comb begin
    w_acc_step = r_acc;
    w_sum      = '0;
    w_qbit     = 1'b0;
    for (int k = 0; k < UNROLL; k++) begin
      if (r_op[2]) begin
        w_sum  = w_acc_step[2*XLEN-1:XLEN-1];
        w_qbit = (w_sum >= {1'b0, r_b});
        if (w_qbit) begin
          w_sum = w_sum - {1'b0, r_b};
        end
        w_acc_step = {w_sum[XLEN-1:0], w_acc_step[XLEN-2:0], w_qbit};
      end else begin
        w_sum = {1'b0, w_acc_step[2*XLEN-1:XLEN]} + (w_acc_step[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
        w_acc_step = {w_sum, w_acc_step[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    w_prod    = r_neg ? (~w_acc_step + 1'b1) : w_acc_step;
    w_fix_res = '0;
    case (r_op)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = r_neg ? (~w_acc_step[XLEN-1:0] + 1'b1)
                                                : w_acc_step[XLEN-1:0];
      default:                w_fix_res = r_neg_rem ? (~w_acc_step[2*XLEN-1:XLEN] + 1'b1)
                                                    : w_acc_step[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? DONE : CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (bus.flush_i) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b       <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else if (w_accept) begin
      r_op      <= bus.funct3_i;
      r_rd      <= bus.rd_i;
      r_neg     <= w_sign_a ^ w_sign_b;
      r_neg_rem <= w_sign_a;
      r_cnt     <= w_special ? '0 : CW'(STEPS);
      if (bus.funct3_i[2]) begin
        r_b   <= w_mag_b;
        r_acc <= {{XLEN{1'b0}}, w_mag_a};
      end else begin
        r_b   <= w_mag_a;
        r_acc <= {{XLEN{1'b0}}, w_mag_b};
      end
      if (w_special) begin
        r_result <= w_special_res;
        r_rd_out <= bus.rd_i;
      end
    end else if ((r_state == CALC) && !bus.flush_i) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt - CW'(1);
      if (w_finish) begin
        r_result <= w_fix_res;
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.busy_o   = (r_state == CALC);
  assign bus.done_o   = (r_state == DONE);
  assign bus.result_o = r_result;
  assign bus.rd_o     = r_rd_out;
  assign bus.state_o  = r_state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: UNROLL=1 and UNROLL=4 instances driven in lockstep, table vectors,
// multi-cycle corner sequences and random operations against an arithmetic reference.
module tb_muldiv_unit;
  logic clk;
  logic rst;

  muldiv_unit_if #(.XLEN(32)) if1 ();
  muldiv_unit_if #(.XLEN(32)) if4 ();

  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (.clk_i(clk), .reset_i(rst), .bus(if1));
  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (.clk_i(clk), .reset_i(rst), .bus(if4));

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q4[$];
  int          n_cmp;
  int          n_err;
  logic [31:0] last_exp1;
  logic [4:0]  last_rd1;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, p;
    logic [63:0] pu;
    int          ia, ib, iq;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ia = a;
    ib = b;
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ($signed({32'd0, b})); return p[63:32]; end
      3'b011: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        iq = ia / ib;
        return iq;
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        iq = ia % ib;
        return iq;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int unroll);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 32 / unroll + 1;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    if1.start_i = st; if1.flush_i = fl; if1.funct3_i = op;
    if1.rs1_i = a;    if1.rs2_i = b;    if1.rd_i = rd;
    if4.start_i = st; if4.flush_i = fl; if4.funct3_i = op;
    if4.rs1_i = a;    if4.rs2_i = b;    if4.rd_i = rd;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat1, lat4, busy1, busy4, el1, el4;
    logic [31:0] r1, r4, e1, e4;
    logic [4:0] d1;
    lat1 = 0; lat4 = 0; busy1 = 0; busy4 = 0;
    r1 = '0; r4 = '0; d1 = '0;
    el1 = exp_lat(op, a, b, 1);
    el4 = exp_lat(op, a, b, 4);
    exp_q1.push_back(exp);
    exp_q4.push_back(exp);
    @(negedge clk); drive(1'b1, 1'b0, op, a, b, rd);
    @(negedge clk); drive(1'b0, 1'b0, op, a, b, rd);
    for (int c = 1; c <= 40; c++) begin
      if (if1.busy_o) busy1++;
      if (if4.busy_o) busy4++;
      if (lat1 == 0 && if1.done_o) begin lat1 = c; r1 = if1.result_o; d1 = if1.rd_o; end
      if (lat4 == 0 && if4.done_o) begin lat4 = c; r4 = if4.result_o; end
      if (lat1 != 0 && lat4 != 0) break;
      @(negedge clk);
    end
    e1 = exp_q1.pop_front();
    e4 = exp_q4.pop_front();
    check({tag, " latency u1"}, lat1, el1);
    check({tag, " latency u4"}, lat4, el4);
    check({tag, " busy cycles u1"}, busy1, el1 - 1);
    check({tag, " busy cycles u4"}, busy4, el4 - 1);
    if (lat1 != 0) begin
      check({tag, " result u1"}, r1, e1);
      check({tag, " rd u1"}, d1, rd);
    end
    if (lat4 != 0) check({tag, " result u4"}, r4, e4);
    last_exp1 = e1;
    last_rd1  = rd;
  endtask

  task automatic seq_flush();
    int n_done;
    @(negedge clk); drive(1'b1, 1'b0, 3'b000, 32'd5, 32'd6, 5'd9);
    @(negedge clk); drive(1'b0, 1'b0, 3'b000, 32'd5, 32'd6, 5'd9);
    repeat (9) @(negedge clk);
    check("flush busy before", if1.busy_o, 1'b1);
    drive(1'b0, 1'b1, 3'b000, 32'd5, 32'd6, 5'd9);
    @(negedge clk); drive(1'b0, 1'b0, 3'b000, 32'd5, 32'd6, 5'd9);
    check("flush busy after", if1.busy_o, 1'b0);
    check("flush done after", if1.done_o, 1'b0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (if1.done_o) n_done++;
      @(negedge clk);
    end
    check("flush no done", n_done, 0);
    check("flush result held", if1.result_o, last_exp1);
    check("flush rd held", if1.rd_o, last_rd1);
  endtask

  task automatic seq_start_flush();
    int n_act;
    @(negedge clk); drive(1'b1, 1'b1, 3'b101, 32'd100, 32'd7, 5'd4);
    @(negedge clk); drive(1'b0, 1'b0, 3'b101, 32'd100, 32'd7, 5'd4);
    n_act = 0;
    for (int c = 0; c < 40; c++) begin
      if (if1.done_o || if1.busy_o || if4.done_o || if4.busy_o) n_act++;
      @(negedge clk);
    end
    check("start+flush not accepted", n_act, 0);
    check("start+flush result held", if1.result_o, last_exp1);
  endtask

  task automatic seq_mid_start();
    int n1, n4, lat1;
    logic [31:0] r1, r4;
    logic [4:0] d1;
    n1 = 0; n4 = 0; lat1 = 0; r1 = '0; r4 = '0; d1 = '0;
    @(negedge clk); drive(1'b1, 1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd21);
    @(negedge clk); drive(1'b0, 1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd21);
    for (int c = 1; c <= 45; c++) begin
      if (if1.done_o) begin
        n1++;
        if (lat1 == 0) begin lat1 = c; r1 = if1.result_o; d1 = if1.rd_o; end
      end
      if (if4.done_o) begin n4++; r4 = if4.result_o; end
      drive(c == 5, 1'b0, 3'b101, 32'd100, 32'd7, 5'd3);
      @(negedge clk);
    end
    check("mid-start latency u1", lat1, 33);
    check("mid-start result u1", r1, 32'hFFFF_FFEB);
    check("mid-start rd u1", d1, 5'd21);
    check("mid-start done count u1", n1, 1);
    check("mid-start done count u4", n4, 1);
    check("mid-start result u4", r4, 32'hFFFF_FFEB);
    last_exp1 = 32'hFFFF_FFEB;
    last_rd1  = 5'd21;
  endtask

  task automatic seq_b2b();
    int lat;
    @(negedge clk); drive(1'b1, 1'b0, 3'b000, 32'd3, 32'd5, 5'd1);
    @(negedge clk); drive(1'b0, 1'b0, 3'b000, 32'd3, 32'd5, 5'd1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (if1.done_o) begin lat = c; break; end
      @(negedge clk);
    end
    check("b2b first latency", lat, 33);
    check("b2b first result", if1.result_o, 32'd15);
    drive(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2);
    @(negedge clk); drive(1'b0, 1'b0, 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (if1.done_o) begin lat = c; break; end
      @(negedge clk);
    end
    check("b2b second latency", lat, 33);
    check("b2b second result", if1.result_o, 32'h4000_0000);
    check("b2b second rd", if1.rd_o, 5'd2);
  endtask

  task automatic seq_reset();
    @(negedge clk); drive(1'b1, 1'b0, 3'b101, 32'd1000, 32'd3, 5'd7);
    @(negedge clk); drive(1'b0, 1'b0, 3'b101, 32'd1000, 32'd3, 5'd7);
    repeat (9) @(negedge clk);
    check("reset pre busy", if1.busy_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async reset busy", if1.busy_o, 1'b0);
    check("async reset done", if1.done_o, 1'b0);
    check("async reset result u1", if1.result_o, 32'd0);
    check("async reset rd u1", if1.rd_o, 5'd0);
    check("async reset state u1", if1.state_o, 2'd0);
    check("async reset result u4", if4.result_o, 32'd0);
    @(negedge clk); rst = 1'b0;
    do_op("post-reset MUL 3x4", 3'b000, 32'd3, 32'd4, 5'd5, 32'd12);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    last_exp1 = '0;
    last_rd1  = '0;
    vecs[0]  = '{"MUL 7*-3",        3'b000, 32'd7,         32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFEB};
    vecs[1]  = '{"MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000};
    vecs[2]  = '{"MULHU 2^31*2^31", 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000};
    vecs[3]  = '{"MULHSU -1*2",     3'b010, 32'hFFFF_FFFF, 32'd2,         5'd13, 32'hFFFF_FFFF};
    vecs[4]  = '{"DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFD};
    vecs[5]  = '{"REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFF};
    vecs[6]  = '{"DIVU 100/7",      3'b101, 32'd100,       32'd7,         5'd16, 32'd14};
    vecs[7]  = '{"REMU 100/7",      3'b111, 32'd100,       32'd7,         5'd17, 32'd2};
    vecs[8]  = '{"DIVU 5/0",        3'b101, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF};
    vecs[9]  = '{"REMU 5/0",        3'b111, 32'd5,         32'd0,         5'd19, 32'd5};
    vecs[10] = '{"DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000};
    vecs[11] = '{"REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0};
    vecs[12] = '{"DIV 5/0",         3'b100, 32'd5,         32'd0,         5'd22, 32'hFFFF_FFFF};
    vecs[13] = '{"REM -5/0",        3'b110, 32'hFFFF_FFFB, 32'd0,         5'd23, 32'hFFFF_FFFB};
    vecs[14] = '{"DIV 7/-2",        3'b100, 32'd7,         32'hFFFF_FFFE, 5'd24, 32'hFFFF_FFFD};
    vecs[15] = '{"REM 7/-2",        3'b110, 32'd7,         32'hFFFF_FFFE, 5'd25, 32'd1};
    vecs[16] = '{"MULH -1*-1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd26, 32'd0};
    vecs[17] = '{"MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd27, 32'hFFFF_FFFE};

    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    repeat (3) @(negedge clk);
    check("reset busy", if1.busy_o, 1'b0);
    check("reset done", if1.done_o, 1'b0);
    check("reset result", if1.result_o, 32'd0);
    check("reset rd", if1.rd_o, 5'd0);
    check("reset state", if1.state_o, 2'd0);
    rst = 1'b0;

    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

    seq_flush();
    seq_start_flush();
    seq_mid_start();
    seq_b2b();

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      op = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      rd = 5'($urandom_range(0, 31));
      do_op($sformatf("rand%0d op%0d", i, op), op, a, b, rd, ref_model(op, a, b));
    end

    seq_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
